// File: rtl/aqp_esp_uart_pkg.sv
// Shared definitions for the ESP UART TX path: beat width, arbiter states,
// default idle-owner timeout.
package aqp_esp_uart_pkg;

   localparam int ESP_UART_DATA_W        = 9;
   localparam int ARB_TIMEOUT_CYCLES_DEF = 1023;

   typedef enum logic {
      IDLE = 1'b0,
      OWN  = 1'b1
   } arb_state_e;

endpackage

// File: rtl/aqp_esp_uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first set request bit found
// searching last_i+1, last_i+2, ... modulo N. Reusable by any shared-resource
// arbiter.
module aqp_rr_pick #(
   parameter int N  = 2,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] last_i,
   output logic          found_o,
   output logic [IW-1:0] idx_o
);

   logic [IW-1:0] cand;

   // Walk candidates from farthest to nearest so the nearest hit wins.
   always_comb begin
      found_o = 1'b0;
      idx_o   = '0;
      cand    = '0;
      for (int k = N; k >= 1; k--) begin
         cand = IW'((int'(last_i) + k) % N);
         if (req_i[cand]) begin
            found_o = 1'b1;
            idx_o   = cand;
         end
      end
   end

endmodule

// File: rtl/aqp_esp_uart_tx_arbiter.sv
// ESP UART TX FIFO write-port arbiter. Grants one requester for a whole
// packet (through its last beat), round-robin between packets. Bit 8 of each
// beat passes through untouched.
// Optional: define AQP_ESP_TX_ARB_TIMEOUT_EN to force release of an owner
// that leaves valid low for TIMEOUT_CYCLES cycles (pulses timeout_err).
module aqp_esp_uart_tx_arbiter
   import aqp_esp_uart_pkg::*;
#(
   parameter int NUM_REQ        = 2,
   parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_CYCLES_DEF
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [NUM_REQ*ESP_UART_DATA_W-1:0] req_data,
   input  logic [NUM_REQ-1:0]                 req_valid,
   input  logic [NUM_REQ-1:0]                 req_last,
   output logic [NUM_REQ-1:0]                 req_ready,
   output logic [ESP_UART_DATA_W-1:0]         fifo_wrdata,
   output logic                               fifo_wr_en,
   input  logic                               fifo_full,
   output logic [NUM_REQ-1:0]                 grant,
   output logic                               timeout_err
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int DW = ESP_UART_DATA_W;

   if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
      $error("aqp_esp_uart_tx_arbiter: illegal NUM_REQ or TIMEOUT_CYCLES");
   end

   arb_state_e         state_q;
   logic [NUM_REQ-1:0] grant_q;
   logic [IW-1:0]      gidx_q;
   logic [IW-1:0]      rr_last_q;

   logic               pick_found;
   logic [IW-1:0]      pick_idx;
   logic               own_valid;
   logic               own_last;
   logic [DW-1:0]      own_data;
   logic               accept;

   aqp_rr_pick #(
      .N  (NUM_REQ),
      .IW (IW)
   ) u_pick (
      .req_i   (req_valid),
      .last_i  (rr_last_q),
      .found_o (pick_found),
      .idx_o   (pick_idx)
   );

   // Select the current owner's valid/last/data slice.
   always_comb begin
      own_valid = 1'b0;
      own_last  = 1'b0;
      own_data  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gidx_q == IW'(i)) begin
            own_valid = req_valid[i];
            own_last  = req_last[i];
            own_data  = req_data[DW*i +: DW];
         end
      end
   end

   assign accept      = (state_q == OWN) & own_valid & ~fifo_full;
   assign fifo_wr_en  = accept;
   assign fifo_wrdata = own_data;
   assign req_ready   = (state_q == OWN && !fifo_full) ? grant_q : '0;
   assign grant       = grant_q;

`ifdef AQP_ESP_TX_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] idle_cnt_q;
   logic          timeout_err_q;
   logic          expire;

   // Owner has sat with valid low for TIMEOUT_CYCLES cycles including this one.
   assign expire      = (state_q == OWN) & ~own_valid & (idle_cnt_q == CW'(TIMEOUT_CYCLES - 1));
   assign timeout_err = timeout_err_q;
`else
   assign timeout_err = 1'b0;
`endif

   // Arbiter FSM: pick in IDLE, hold ownership until last beat (or timeout).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         gidx_q    <= '0;
         rr_last_q <= IW'(NUM_REQ - 1);
`ifdef AQP_ESP_TX_ARB_TIMEOUT_EN
         idle_cnt_q    <= '0;
         timeout_err_q <= 1'b0;
`endif
      end else begin
`ifdef AQP_ESP_TX_ARB_TIMEOUT_EN
         timeout_err_q <= 1'b0;
`endif
         case (state_q)
            IDLE: begin
               if (pick_found) begin
                  grant_q <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
                  gidx_q  <= pick_idx;
                  state_q <= OWN;
`ifdef AQP_ESP_TX_ARB_TIMEOUT_EN
                  idle_cnt_q <= '0;
`endif
               end
            end
            OWN: begin
               if (accept && own_last) begin
                  rr_last_q <= gidx_q;
                  grant_q   <= '0;
                  state_q   <= IDLE;
               end
`ifdef AQP_ESP_TX_ARB_TIMEOUT_EN
               else if (accept) begin
                  idle_cnt_q <= '0;
               end else if (expire) begin
                  rr_last_q     <= gidx_q;
                  grant_q       <= '0;
                  state_q       <= IDLE;
                  timeout_err_q <= 1'b1;
               end else if (!own_valid) begin
                  idle_cnt_q <= idle_cnt_q + 1'b1;
               end
`endif
            end
            default: begin
               state_q <= IDLE;
               grant_q <= '0;
            end
         endcase
      end
   end

endmodule
